// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider sequencer.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left by one, subtract
// the divisor from the widened partial remainder and keep the difference
// when it does not go negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           fits;

  // Trial subtraction; a set shifted MSB means the value already exceeds any divisor.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    fits     = shifted[WIDTH] | ~trial[WIDTH];
    rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: holds the pipeline while a restoring
// divide runs one quotient bit per cycle, then pulses done with the
// quotient on q (LO) and remainder on r (HI).
// Optional DIV_CTRL_ZERO_FAST_EN: zero divisor skips the iterations and
// raises the registered div_zero flag.
module div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             du,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
`ifdef DIV_CTRL_ZERO_FAST_EN
  ,
  output logic             div_zero
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state, state_next;
  logic             du_r, sa, sb;
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH-1:0] rem, quo;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [CNT_W-1:0] cnt;
  logic             accept_state;
  logic             opb_zero;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (opb),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // Operand magnitudes for signed mode; the most negative value maps to itself.
  always_comb begin
    a_mag    = (~du_r & opa[WIDTH-1]) ? ('0 - opa) : opa;
    b_mag    = (~du_r & opb[WIDTH-1]) ? ('0 - opb) : opb;
    opb_zero = (opb == '0);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and handshake outputs; flush beats start in busy states.
  always_comb begin
    state_next   = state;
    busy         = 1'b0;
    done         = 1'b0;
    accept_state = 1'b0;
    case (state)
      IDLE: begin
        accept_state = 1'b1;
        if (start) state_next = PREP;
      end
      PREP: begin
        busy = 1'b1;
        if (flush) state_next = IDLE;
`ifdef DIV_CTRL_ZERO_FAST_EN
        else if (opb_zero) state_next = FIX;
`endif
        else state_next = ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (flush)           state_next = IDLE;
        else if (cnt == '0)  state_next = FIX;
      end
      FIX: begin
        busy = 1'b1;
        state_next = flush ? IDLE : DONE;
      end
      DONE: begin
        done         = 1'b1;
        accept_state = 1'b1;
        state_next   = start ? PREP : IDLE;
      end
      default: state_next = IDLE;
    endcase
    stall = (start & accept_state) | busy;
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      du_r <= 1'b0;
      sa   <= 1'b0;
      sb   <= 1'b0;
      opa  <= '0;
      opb  <= '0;
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
      q    <= '0;
      r    <= '0;
`ifdef DIV_CTRL_ZERO_FAST_EN
      div_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            du_r <= du;
            opa  <= dividend;
            opb  <= divisor;
`ifdef DIV_CTRL_ZERO_FAST_EN
            div_zero <= 1'b0;
`endif
          end
        end
        PREP: begin
          sa  <= ~du_r & opa[WIDTH-1];
          sb  <= ~du_r & opb[WIDTH-1];
          opb <= b_mag;
          rem <= '0;
          quo <= a_mag;
          cnt <= CNT_W'(WIDTH - 1);
`ifdef DIV_CTRL_ZERO_FAST_EN
          // Preload what WIDTH iterations against zero would have produced.
          if (opb_zero) begin
            rem <= a_mag;
            quo <= '1;
          end
`endif
        end
        ITER: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          if (!flush) begin
            q <= (sa ^ sb) ? ('0 - quo) : quo;
            r <= sa ? ('0 - rem) : rem;
`ifdef DIV_CTRL_ZERO_FAST_EN
            div_zero <= opb_zero;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: table of divide vectors plus flush, reset
// and back-to-back sequences.
module tb_div_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        du;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
`ifdef DIV_CTRL_ZERO_FAST_EN
  logic        div_zero;
`endif

  int checks;
  int failures;

  div_ctrl #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .du       (du),
    .dividend (dividend),
    .divisor  (divisor),
    .flush    (flush),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .q        (q),
    .r        (r)
`ifdef DIV_CTRL_ZERO_FAST_EN
    ,
    .div_zero (div_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        du;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eq;
    logic [31:0] er;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present a request mid-cycle; returns in cycle 1 after the accepting edge.
  task automatic issue(input logic d, input logic [31:0] a, input logic [31:0] b, input string name);
    du       = d;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    #1;
    chk({name, "_stall_start"}, {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts cycles from cycle 1 until done, bounded.
  task automatic wait_done(output int lat, output logic busy_ok);
    int k;
    lat     = -1;
    busy_ok = 1'b1;
    k       = 1;
    while (k <= 60 && lat < 0) begin
      if (done) lat = k;
      else begin
        if (!busy) busy_ok = 1'b0;
        @(posedge clk); #1;
        k++;
      end
    end
  endtask

  initial begin
    int          lat;
    int          exp_lat;
    logic        bok;
    logic [31:0] prev_q, prev_r;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    du       = 1'b0;
    dividend = '0;
    divisor  = '0;
    flush    = 1'b0;

    vecs[0]  = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2]  = '{1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vecs[3]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    vecs[5]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFB,  32'd0,          32'd1,          32'hFFFF_FFFB};
    vecs[7]  = '{1'b0, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
    vecs[8]  = '{1'b1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[9]  = '{1'b1, 32'd12345678,   32'd10000,      32'd1234,       32'd5678};
    vecs[10] = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0};
    vecs[11] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          32'd1};

    // Reset state
    #1;
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_done",  {31'd0, done},  32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_r", r, 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven divides
    for (int i = 0; i < NV; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      exp_lat = 35;
`ifdef DIV_CTRL_ZERO_FAST_EN
      if (vecs[i].b == 32'd0) exp_lat = 3;
`endif
      issue(vecs[i].du, vecs[i].a, vecs[i].b, nm);
      wait_done(lat, bok);
      chk({nm, "_latency"}, lat, exp_lat);
      chk({nm, "_busy_during"}, {31'd0, bok}, 32'd1);
      chk({nm, "_q"}, q, vecs[i].eq);
      chk({nm, "_r"}, r, vecs[i].er);
      chk({nm, "_stall_done"}, {31'd0, stall}, 32'd0);
      chk({nm, "_busy_done"}, {31'd0, busy}, 32'd0);
`ifdef DIV_CTRL_ZERO_FAST_EN
      chk({nm, "_div_zero"}, {31'd0, div_zero}, {31'd0, (vecs[i].b == 32'd0)});
`endif
      @(posedge clk); #1;
      chk({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
    end
    prev_q = vecs[NV-1].eq;
    prev_r = vecs[NV-1].er;

    // Flush in cycle 10: idle in cycle 11, results untouched, restart at 12
    issue(1'b1, 32'd1000, 32'd3, "flush");
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy11", {31'd0, busy}, 32'd0);
    chk("flush_done11", {31'd0, done}, 32'd0);
    chk("flush_q_hold", q, prev_q);
    chk("flush_r_hold", r, prev_r);
    @(posedge clk); #1;
    chk("flush_done12", {31'd0, done}, 32'd0);
    issue(1'b1, 32'd1000, 32'd3, "flush_restart");
    wait_done(lat, bok);
    chk("flush_restart_latency", lat, 32'd35);
    chk("flush_restart_q", q, 32'd333);
    chk("flush_restart_r", r, 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset in cycle 20
    issue(1'b0, 32'hFFFF_FF9C, 32'd7, "rst_mid");
    repeat (19) begin @(posedge clk); #1; end
    chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_q", q, 32'd0);
    chk("rst_mid_r", r, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_idle", {31'd0, busy}, 32'd0);

    // Back-to-back: second start held during the done cycle
    issue(1'b1, 32'd100, 32'd7, "b2b_a");
    wait_done(lat, bok);
    chk("b2b_a_latency", lat, 32'd35);
    chk("b2b_a_q", q, 32'd14);
    chk("b2b_a_r", r, 32'd2);
    issue(1'b0, 32'hFFFF_FFF9, 32'd2, "b2b_b");
    wait_done(lat, bok);
    chk("b2b_b_latency", lat, 32'd35);
    chk("b2b_b_busy_during", {31'd0, bok}, 32'd1);
    chk("b2b_b_q", q, 32'hFFFF_FFFD);
    chk("b2b_b_r", r, 32'hFFFF_FFFF);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle sequencer for integer division in the MIPS54 core. It takes one DIV/DIVU request from the EX stage and holds the pipeline while the divide runs. The divide is an iterative restoring algorithm, one quotient bit per cycle. When finished, the block pulses a HI/LO write with quotient → LO and remainder → HI. It replaces the single-cycle combinational divide path so that the divide no longer limits the core clock.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width.
- `clk`, in, 1: core clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request a divide. Sampled only in IDLE or DONE.
- `du`, in, 1: operation select. 1 = unsigned (DIVU), 0 = signed (DIV).
- `dividend`, in, WIDTH: captured on the accepting edge.
- `divisor`, in, WIDTH: captured on the accepting edge.
- `flush`, in, 1: synchronous cancel from exception or branch logic.
- `busy`, out, 1: a divide is in progress.
- `stall`, out, 1: combinational pipeline hold. Equals `(start & accept_state) | busy`.
- `done`, out, 1: one-cycle pulse. Doubles as the HI/LO write enable.
- `q`, out, WIDTH: registered quotient, routed to LO.
- `r`, out, WIDTH: registered remainder, routed to HI.
- `div_zero`, out, 1: present only when `DIV_CTRL_ZERO_FAST_EN` is defined (see Configuration).

## Operation
- FSM states: IDLE, PREP, ITER, FIX, DONE.
- IDLE or DONE, with `start`=1: latch `du` and both operands, then go to PREP.
- PREP:
  - Signed mode: record `sa` (dividend sign) and `sb` (divisor sign), and load the absolute values. |−2^31| is taken as the unsigned value 0x80000000.
  - Unsigned mode: load the operands unchanged.
  - Clear the partial remainder and set the iteration counter to WIDTH−1. Go to ITER.
- ITER, one restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial = rem − divisor, computed in WIDTH+1 bits.
  - If the trial is non-negative, keep it as rem and set quo[0]=1.
  - Decrement the counter. When the counter is 0, go to FIX.
- FIX:
  - Signed mode: negate q if `sa^sb`, and negate r if `sa`.
  - Unsigned mode: pass q and r through.
  - Write the results to `q`/`r`. Go to DONE.
- DONE: assert `done` for exactly one cycle, then go to IDLE. A `start` in this cycle is accepted and goes directly to PREP.
- Result semantics:
  - The quotient truncates toward zero, and the remainder takes the sign of the dividend (MIPS semantics).
  - Overflow case −2^31 / −1 gives q=0x80000000, r=0.
- Divisor zero produces no exception. Results are defined by the algorithm:
  - Unsigned: q=0xFFFFFFFF, r=dividend.
  - Signed: q=0xFFFFFFFF when dividend ≥ 0, q=0x00000001 when dividend < 0; r=dividend.
- `start` while busy is ignored. EX is stalled during this time, so this case occurs only on a protocol error.
- `flush` while in PREP, ITER or FIX:
  - Next state is IDLE.
  - No `done` pulse.
  - `q`/`r` keep their previous values.
  - `flush` has priority over `start` in the same cycle.
- Asynchronous reset, including mid-operation: state=IDLE, `busy`=0, `done`=0, `q`=0, `r`=0, counter=0.

## Timing
- Reset values: `busy`=0, `done`=0, `stall`=0 (given `start`=0), `q`=0, `r`=0.
- `start` accepted at edge 0. Then:
  - Cycle 1: PREP.
  - Cycles 2–33: ITER (WIDTH cycles).
  - Cycle 34: FIX.
  - Cycle 35: DONE, with `done`=1.
- Latency: 35 cycles from the accepting edge to `done`. Back-to-back issue gives one divide per 35 cycles.
- `busy` is high in cycles 1–34 and low in DONE.
- `stall` is high from the `start` cycle through cycle 34. It is low in the `done` cycle, so EX/MEM advances with valid HI/LO.
- `q`/`r` are valid from the `done` cycle and hold until the next FIX.

## Configuration
- `DIV_CTRL_ZERO_FAST_EN` defined:
  - When the latched divisor is 0, PREP goes straight to FIX. The results are the same as in the no-fast-path case.
  - `done` arrives in cycle 3.
  - `div_zero` is a registered flag. It is set in FIX for a zero divisor and cleared by the next accepted `start` or by reset.
- Macro not defined:
  - No `div_zero` port.
  - Divisor zero takes the full 35 cycles.

## Structure
- Package `div_pkg` holds:
  - the state enum `div_state_t` (IDLE, PREP, ITER, FIX, DONE);
  - `DIV_WIDTH = 32`;
  - `DIV_CNT_W = $clog2(DIV_WIDTH)`.
- Sub-module `div_step`: one combinational restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - `div_ctrl` holds all registers and the FSM.

## Test plan
- Unsigned: `du`=1, 100 / 7 → `done` at cycle 35, q=14, r=2. `busy` high in cycles 1–34.
- Signed: `du`=0, −7 / 2 → q=0xFFFFFFFD (−3), r=0xFFFFFFFF (−1). Also 7 / −2 → q=−3, r=1.
- Overflow: 0x80000000 / 0xFFFFFFFF signed → q=0x80000000, r=0. Same operands with `du`=1 → q=0, r=0x80000000.
- Divisor zero, unsigned 5 / 0 → q=0xFFFFFFFF, r=5. `done` at cycle 35, or at cycle 3 with `div_zero`=1 when `DIV_CTRL_ZERO_FAST_EN` is defined.
- Flush at cycle 10 → IDLE at cycle 11, no `done`, `q`/`r` unchanged. A new `start` at cycle 12 completes normally 35 cycles later.
- Reset mid-op: `rst_n` low at cycle 20 → `busy`=0, `q`=0, `r`=0 immediately. Back-to-back: `start` held high in the DONE cycle is accepted, and the next `done` follows 35 cycles later.
